// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: command codes, error
// bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_MOD = 4'd5;

    localparam int ERR_OVF = 0;
    localparam int ERR_DBZ = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_t;

    // Anything outside ADD..MOD is not a real ALU operation.
    function automatic logic cmd_is_illegal(input logic [3:0] cmd);
        return (cmd == CMD_NOP) || (cmd > CMD_MOD);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Stops at all-ones instead of wrapping back to zero.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
    endfunction

    // Next count: advance only when asked.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    // Count register; the clear is the only way back to zero.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked front-end for the combinational ALU: accepts a request, holds the
// ALU operands for a settle window, captures result/error and returns them
// over a valid/ready response channel. Also keeps a chaining accumulator and
// a saturating count of erroneous responses.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int RES_W         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_cmd,
    input  logic [DATA_W-1:0]   req_opa,
    input  logic [DATA_W-1:0]   req_opb,
    input  logic                req_use_acc,
    input  logic                clear_acc,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_cmd,
    input  logic [RES_W-1:0]    alu_result,
    input  logic [1:0]          alu_error,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RES_W-1:0]    rsp_result,
    output logic [1:0]          rsp_error,
    output logic                rsp_illegal,
    output logic [RES_W-1:0]    acc,
    output logic [ERRCNT_W-1:0] err_count
);

    // The settle counter runs down to zero; zero marks the capture cycle.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t        state_q,       state_d;
    logic [3:0]        cnt_q,         cnt_d;
    logic              req_ready_q,   req_ready_d;
    logic [DATA_W-1:0] alu_a_q,       alu_a_d;
    logic [DATA_W-1:0] alu_b_q,       alu_b_d;
    logic [3:0]        alu_cmd_q,     alu_cmd_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [RES_W-1:0]  rsp_result_q,  rsp_result_d;
    logic [1:0]        rsp_error_q,   rsp_error_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [RES_W-1:0]  acc_q,         acc_d;
    logic              capture;
    logic              cap_illegal;
    logic              err_inc;

    assign cap_illegal = cmd_is_illegal(alu_cmd_q);

    // Next-state and datapath decode for the request/settle/response cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cmd_d     = alu_cmd_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_error_d   = rsp_error_q;
        rsp_illegal_d = rsp_illegal_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    // acc_q here is the pre-clear value even if clear_acc is high.
                    alu_a_d   = req_use_acc ? acc_q[DATA_W-1:0] : req_opa;
                    alu_b_d   = req_opb;
                    alu_cmd_d = req_cmd;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    capture       = 1'b1;
                    rsp_result_d  = alu_result;
                    rsp_error_d   = alu_error;
                    rsp_illegal_d = cap_illegal;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // Accumulator update: clear wins over a capture in the same cycle;
    // divide-by-zero and illegal commands leave it untouched.
    always_comb begin
        acc_d = acc_q;
        if (clear_acc) begin
            acc_d = '0;
        end else if (capture && !cap_illegal && !alu_error[ERR_DBZ]) begin
            acc_d = alu_result;
        end
    end

    assign err_inc = capture && ((alu_error != 2'b00) || cap_illegal);

    // All sequencer state, registered outputs included; reset aborts any
    // operation in flight without producing a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            req_ready_q   <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cmd_q     <= 4'd0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_error_q   <= 2'b00;
            rsp_illegal_q <= 1'b0;
            acc_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cmd_q     <= alu_cmd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_error_q   <= rsp_error_d;
            rsp_illegal_q <= rsp_illegal_d;
            acc_q         <= acc_d;
        end
    end

    sat_counter #(
        .WIDTH (ERRCNT_W)
    ) u_err_count (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (err_inc),
        .count (err_count)
    );

    assign req_ready   = req_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cmd     = alu_cmd_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_illegal = rsp_illegal_q;
    assign acc         = acc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU drives the ALU
// ports, a driver issues requests and predicts responses, a monitor checks.
module tb_alu_op_sequencer;

    localparam int DW = 16;
    localparam int RW = 32;
    localparam int EW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT with SETTLE_CYCLES=1 ----------------
    logic          rst_n, req_valid, req_ready, req_use_acc, clear_acc;
    logic [3:0]    req_cmd, alu_cmd;
    logic [DW-1:0] req_opa, req_opb, alu_a, alu_b;
    logic [RW-1:0] alu_result, rsp_result, acc;
    logic [1:0]    alu_error, rsp_error;
    logic          rsp_valid, rsp_ready, rsp_illegal;
    logic [EW-1:0] err_count;

    // ---------------- DUT with SETTLE_CYCLES=3 ----------------
    logic          rst3_n, v3, ready3;
    logic [3:0]    cmd3, alu_cmd3;
    logic [DW-1:0] a3, b3, alu_a3, alu_b3;
    logic [RW-1:0] alu_result3, rsp_result3, acc3;
    logic [1:0]    alu_error3, rsp_error3;
    logic          rsp_valid3, rsp_illegal3;
    logic [EW-1:0] err_count3;

    // Behavioural ALU: 16-bit unsigned operands, 32-bit result,
    // error[1]=divide-by-zero, error[0]=overflow; unknown commands give 0.
    function automatic logic [RW+1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] c);
        logic [RW-1:0] r;
        logic [1:0]    e;
        r = '0;
        e = 2'b00;
        case (c)
            4'd1: begin r = RW'(a) + RW'(b); e[0] = (r > 32'h0000_FFFF); end
            4'd2: begin r = RW'(a) - RW'(b); e[0] = (a < b); end
            4'd3: r = RW'(a) * RW'(b);
            4'd4: if (b == 0) e[1] = 1'b1; else r = RW'(a / b);
            4'd5: if (b == 0) e[1] = 1'b1; else r = RW'(a % b);
            default: ;
        endcase
        return {e, r};
    endfunction

    assign {alu_error, alu_result}   = alu_fn(alu_a, alu_b, alu_cmd);
    assign {alu_error3, alu_result3} = alu_fn(alu_a3, alu_b3, alu_cmd3);

    // Response-ready source: either forced by the main sequence or random.
    bit   rdy_mode  = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_rdy   = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_rdy = (($urandom % 3) != 0);
    end
    assign rsp_ready = rdy_mode ? rnd_rdy : rdy_force;

    alu_op_sequencer #(
        .DATA_W(DW), .RES_W(RW), .SETTLE_CYCLES(1), .ERRCNT_W(EW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_opa(req_opa), .req_opb(req_opb), .req_use_acc(req_use_acc),
        .clear_acc(clear_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_illegal(rsp_illegal),
        .acc(acc), .err_count(err_count)
    );

    alu_op_sequencer #(
        .DATA_W(DW), .RES_W(RW), .SETTLE_CYCLES(3), .ERRCNT_W(EW)
    ) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req_valid(v3), .req_ready(ready3), .req_cmd(cmd3),
        .req_opa(a3), .req_opb(b3), .req_use_acc(1'b0),
        .clear_acc(1'b0),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_cmd(alu_cmd3),
        .alu_result(alu_result3), .alu_error(alu_error3),
        .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_result(rsp_result3),
        .rsp_error(rsp_error3), .rsp_illegal(rsp_illegal3),
        .acc(acc3), .err_count(err_count3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [RW-1:0] res;
        logic [1:0]    err;
        logic          ill;
        logic [RW-1:0] acc;
        int            ecnt;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            acc_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    logic [RW-1:0] m_acc  = '0;
    int            m_ecnt = 0;

    logic [RW-1:0] last_res = '0;
    logic [1:0]    last_err = 2'b00;
    logic          last_ill = 1'b0;
    int            hs_cyc   = 0;
    bit            in_rsp   = 1'b0;

    // Monitor: every response cycle is checked against the head of the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 1'b0;
        end else if (rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = sbq[0];
                chk("rsp_result",  rsp_result,  mon_e.res);
                chk("rsp_error",   rsp_error,   mon_e.err);
                chk("rsp_illegal", rsp_illegal, mon_e.ill);
                chk("req_ready_busy", req_ready, 64'd0);
                if (!in_rsp) begin
                    chk("acc_after_capture", acc, mon_e.acc);
                    chk("err_count", err_count, 64'(mon_e.ecnt));
                    chk("alu_a_port", alu_a, mon_e.a);
                    chk("alu_b_port", alu_b, mon_e.b);
                    chk("rsp_latency", 64'(cyc - mon_e.acc_cyc), 64'd1);
                end
                in_rsp = 1'b1;
                if (rsp_ready) begin
                    last_res = rsp_result;
                    last_err = rsp_error;
                    last_ill = rsp_illegal;
                    hs_cyc   = cyc + 1;
                    void'(sbq.pop_front());
                    in_rsp = 1'b0;
                end
            end
        end
    end

    // Issue one request; predicts the response at the point of acceptance.
    // clr_acc asserts clear_acc on the accepting edge; clr_cap on the capture edge.
    task automatic issue(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit ua, input bit clr_acc, input bit clr_cap);
        exp_t          e;
        logic [RW+1:0] r;
        logic [DW-1:0] opa;
        int            n;
        req_cmd     = c;
        req_opa     = a;
        req_opb     = b;
        req_use_acc = ua;
        req_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (clr_acc) clear_acc = 1'b1;
        opa = ua ? m_acc[DW-1:0] : a;
        if (clr_acc) m_acc = '0;
        r         = alu_fn(opa, b, c);
        e.res     = r[RW-1:0];
        e.err     = r[RW+1:RW];
        e.ill     = (c == 4'd0) || (c > 4'd5);
        e.a       = opa;
        e.b       = b;
        e.acc_cyc = cyc + 1;
        if (clr_cap) m_acc = '0;
        else if (!e.ill && !e.err[1]) m_acc = e.res;
        if ((e.err != 2'b00 || e.ill) && m_ecnt < 255) m_ecnt++;
        e.acc  = m_acc;
        e.ecnt = m_ecnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        clear_acc = clr_cap;
        if (clr_cap) begin
            @(posedge clk);
            #1;
            clear_acc = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int            n;
        int            t_acc;
        bit            seen;
        logic [3:0]    rc;
        logic [DW-1:0] ra, rb;

        rst_n = 1'b0; rst3_n = 1'b0;
        req_valid = 1'b0; req_cmd = 4'd0; req_opa = '0; req_opb = '0;
        req_use_acc = 1'b0; clear_acc = 1'b0;
        v3 = 1'b0; cmd3 = 4'd0; a3 = '0; b3 = '0;
        rdy_mode = 1'b0; rdy_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst3_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_req_ready", req_ready, 64'd1);
        chk("reset_rsp_valid", rsp_valid, 64'd0);
        chk("reset_alu_a", alu_a, 64'd0);
        chk("reset_alu_cmd", alu_cmd, 64'd0);
        chk("reset_acc", acc, 64'd0);
        chk("reset_err_count", err_count, 64'd0);
        @(posedge clk);
        #1;

        // Basic ADD/SUB/MUL with acc tracking
        issue(4'd1, 16'd249, 16'd69, 1'b0, 1'b0, 1'b0); drain();
        chk("add_result", last_res, 64'd318);
        chk("add_acc", acc, 64'd318);
        issue(4'd2, 16'd249, 16'd69, 1'b0, 1'b0, 1'b0); drain();
        chk("sub_result", last_res, 64'd180);
        chk("sub_error", last_err, 64'd0);
        issue(4'd3, 16'd249, 16'd69, 1'b0, 1'b0, 1'b0); drain();
        chk("mul_result", last_res, 64'd17181);
        chk("mul_acc", acc, 64'd17181);

        // Clear then chain through the accumulator
        issue(4'd1, 16'd0, 16'd10, 1'b0, 1'b1, 1'b0); drain();
        issue(4'd1, 16'd999, 16'd5, 1'b1, 1'b0, 1'b0); drain();
        chk("chain_result", last_res, 64'd15);
        chk("chain_alu_a", alu_a, 64'd10);
        chk("chain_acc", acc, 64'd15);

        // Divide by zero, then an illegal command
        issue(4'd4, 16'd5, 16'd0, 1'b0, 1'b0, 1'b0); drain();
        chk("dbz_error", last_err, 64'd2);
        chk("dbz_acc_kept", acc, 64'd15);
        chk("dbz_err_count", err_count, 64'd1);
        issue(4'd7, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0); drain();
        chk("illegal_flag", last_ill, 64'd1);
        chk("illegal_result", last_res, 64'd0);
        chk("illegal_err_count", err_count, 64'd2);
        chk("illegal_acc_kept", acc, 64'd15);

        // Backpressure: 3 cycles stalled with a request waiting, handshake on the 4th
        rdy_force = 1'b0;
        issue(4'd1, 16'd100, 16'd23, 1'b0, 1'b0, 1'b0);
        req_cmd = 4'd2; req_opa = 16'd500; req_opb = 16'd1; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_rsp_seen", rsp_valid, 64'd1);
        repeat (2) @(negedge clk);
        chk("bp_still_valid", rsp_valid, 64'd1);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        issue(4'd3, 16'd7, 16'd9, 1'b0, 1'b0, 1'b0);
        chk("bp_next_accept_gap", 64'(sbq[sbq.size()-1].acc_cyc - hs_cyc), 64'd1);
        drain();
        chk("bp_second_result", last_res, 64'd63);

        // Randomised traffic with random response backpressure
        rdy_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            rc = (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'(1 + ($urandom % 5));
            ra = 16'($urandom);
            rb = (($urandom % 6) == 0) ? 16'd0 :
                 ((($urandom % 2) == 0) ? 16'($urandom % 300) : 16'($urandom));
            issue(rc, ra, rb, ($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0);
        end
        drain();
        rdy_mode = 1'b0;
        rdy_force = 1'b1;

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            issue(4'd4, 16'($urandom), 16'd0, 1'b0, 1'b0, 1'b0);
        end
        drain();
        chk("errcnt_saturated", err_count, 64'd255);

        // clear_acc coinciding with a legal capture
        issue(4'd1, 16'd3, 16'd4, 1'b0, 1'b0, 1'b1); drain();
        chk("clear_on_capture_result", last_res, 64'd7);
        chk("clear_on_capture_acc", acc, 64'd0);
        chk("errcnt_stays_255", err_count, 64'd255);

        // SETTLE_CYCLES=3 instance: latency, then reset mid-SETTLE
        v3 = 1'b1; cmd3 = 4'd1; a3 = 16'd7; b3 = 16'd8;
        @(negedge clk);
        chk("s3_ready", ready3, 64'd1);
        t_acc = cyc + 1;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid3 && n < 20) begin @(negedge clk); n++; end
        chk("s3_latency", 64'(cyc - t_acc), 64'd3);
        chk("s3_result", rsp_result3, 64'd15);
        chk("s3_acc", acc3, 64'd15);
        n = 0;
        @(negedge clk);
        while (!ready3 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        v3 = 1'b1; cmd3 = 4'd3; a3 = 16'd2; b3 = 16'd3;
        @(negedge clk);
        chk("s3_ready2", ready3, 64'd1);
        @(posedge clk);          // accepting edge
        #1;
        v3 = 1'b0;               // first SETTLE cycle
        @(posedge clk);
        #1;
        rst3_n = 1'b0;           // second SETTLE cycle
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", ready3, 64'd1);
        chk("abort_rsp_valid", rsp_valid3, 64'd0);
        chk("abort_alu_a", alu_a3, 64'd0);
        chk("abort_alu_b", alu_b3, 64'd0);
        chk("abort_alu_cmd", alu_cmd3, 64'd0);
        chk("abort_acc", acc3, 64'd0);
        chk("abort_rsp_result", rsp_result3, 64'd0);
        chk("abort_err_count", err_count3, 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid3) seen = 1'b1;
        end
        chk("abort_no_response", seen, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
